// File: rtl/vop2_operand_fetch_if.sv
// VOP2 operand fetch bus: instruction in, literal in, SGPR/VGPR read ports,
// and the resolved-operand handshake toward the ALU.
interface vop2_operand_fetch_if #(
  parameter int DATA_W  = 32,
  parameter int VGPR_AW = 8,
  parameter int SGPR_AW = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              lit_valid;
  logic              lit_ready;
  logic [DATA_W-1:0] lit_data;
  logic              sgpr_re;
  logic [SGPR_AW-1:0] sgpr_addr;
  logic [DATA_W-1:0] sgpr_rdata;
  logic              vgpr_re;
  logic [VGPR_AW-1:0] vgpr_addr;
  logic [DATA_W-1:0] vgpr_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_op;
  logic [7:0]        out_vdst;
  logic [DATA_W-1:0] out_src0;
  logic [DATA_W-1:0] out_src1;
  logic              out_err;

  // Environment side: issues instructions/literals, owns the register files, consumes results
  modport master (
    output in_valid, in_instr, lit_valid, lit_data, sgpr_rdata, vgpr_rdata, out_ready,
    input  in_ready, lit_ready, sgpr_re, sgpr_addr, vgpr_re, vgpr_addr,
    input  out_valid, out_op, out_vdst, out_src0, out_src1, out_err
  );

  // Fetch block side
  modport slave (
    input  in_valid, in_instr, lit_valid, lit_data, sgpr_rdata, vgpr_rdata, out_ready,
    output in_ready, lit_ready, sgpr_re, sgpr_addr, vgpr_re, vgpr_addr,
    output out_valid, out_op, out_vdst, out_src0, out_src1, out_err
  );
endinterface

// File: rtl/vop2_operand_fetch.sv
// VOP2 operand fetch: decodes src0 (SGPR, VGPR, inline constant, literal or
// illegal), reads vsrc1 from the VGPR file, and presents both resolved
// operands plus op/vdst to the ALU with a valid/ready handshake.
module vop2_operand_fetch #(
  parameter int DATA_W  = 32,
  parameter int VGPR_AW = 8,
  parameter int SGPR_AW = 7
) (
  input  logic clk,
  input  logic rst_n,
  vop2_operand_fetch_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LIT, RS0, RV0, RV1, WAIT, OUT} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [8:0]                src0_q;
  logic [7:0]                vsrc1_q;
  logic                      from_sgpr_q;
  logic                      from_vgpr_q;
  logic [5:0]                op_q;
  logic [7:0]                vdst_q;
  logic signed [DATA_W-1:0]  src0_val;
  logic signed [DATA_W-1:0]  src1_val;
  logic                      err_q;
  logic                      accept;
  logic [8:0]                src0_in;
  logic                      sgpr_re;
  logic [SGPR_AW-1:0]        sgpr_addr;
  logic                      vgpr_re;
  logic [VGPR_AW-1:0]        vgpr_addr;

  // Inline constant table: 128 -> 0, 129..192 -> 1..64, 193..208 -> -1..-16
  function automatic logic signed [DATA_W-1:0] inline_const(input logic [8:0] code);
    int v;
    if (code <= 9'd192) v = int'(code) - 128;
    else                v = 192 - int'(code);
    return DATA_W'(v);
  endfunction

  assign src0_in       = bus.in_instr[8:0];
  assign bus.in_ready  = (state == IDLE) && rst_n;
  assign bus.lit_ready = (state == LIT);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.sgpr_re   = sgpr_re;
  assign bus.sgpr_addr = sgpr_addr;
  assign bus.vgpr_re   = vgpr_re;
  assign bus.vgpr_addr = vgpr_addr;
  assign bus.out_valid = (state == OUT);
  assign bus.out_op    = op_q;
  assign bus.out_vdst  = vdst_q;
  assign bus.out_src0  = src0_val;
  assign bus.out_src1  = src1_val;
  assign bus.out_err   = err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and register-file read strobes (one read port per file)
  always_comb begin
    state_nxt = state;
    sgpr_re   = 1'b0;
    sgpr_addr = '0;
    vgpr_re   = 1'b0;
    vgpr_addr = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (src0_in <= 9'd127)      state_nxt = RS0;
          else if (src0_in <= 9'd254) state_nxt = RV1;
          else if (src0_in == 9'd255) state_nxt = LIT;
          else                        state_nxt = RV0;
        end
      end
      LIT: begin
        if (bus.lit_valid) state_nxt = RV1;
      end
      RS0: begin
        sgpr_re   = 1'b1;
        sgpr_addr = SGPR_AW'(src0_q[6:0]);
        state_nxt = RV1;
      end
      RV0: begin
        vgpr_re   = 1'b1;
        vgpr_addr = VGPR_AW'(src0_q[7:0]);
        state_nxt = RV1;
      end
      RV1: begin
        vgpr_re   = 1'b1;
        vgpr_addr = VGPR_AW'(vsrc1_q);
        state_nxt = WAIT;
      end
      WAIT: state_nxt = OUT;
      OUT: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Field latches and operand capture; every register clears on reset so a
  // discarded instruction leaves nothing visible on the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src0_q      <= '0;
      vsrc1_q     <= '0;
      from_sgpr_q <= 1'b0;
      from_vgpr_q <= 1'b0;
      op_q        <= '0;
      vdst_q      <= '0;
      src0_val    <= '0;
      src1_val    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            src0_q      <= src0_in;
            vsrc1_q     <= bus.in_instr[16:9];
            vdst_q      <= bus.in_instr[24:17];
            op_q        <= bus.in_instr[30:25];
            err_q       <= 1'b0;
            from_sgpr_q <= (src0_in <= 9'd127);
            from_vgpr_q <= src0_in[8];
            if (src0_in >= 9'd128 && src0_in <= 9'd208) begin
              src0_val <= inline_const(src0_in);
            end else if (src0_in >= 9'd209 && src0_in <= 9'd254) begin
              src0_val <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        LIT: begin
          if (bus.lit_valid) src0_val <= bus.lit_data;
        end
        RV1: begin
          if (from_sgpr_q)      src0_val <= bus.sgpr_rdata;
          else if (from_vgpr_q) src0_val <= bus.vgpr_rdata;
        end
        WAIT: src1_val <= bus.vgpr_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vop2_operand_fetch.sv
// Testbench for vop2_operand_fetch: directed vector table, random
// instructions against a register-file/operand model, and reset corner cases.
module tb_vop2_operand_fetch;

  logic clk;
  logic rst_n;

  vop2_operand_fetch_if #(.DATA_W(32), .VGPR_AW(8), .SGPR_AW(7)) bus ();

  vop2_operand_fetch #(.DATA_W(32), .VGPR_AW(8), .SGPR_AW(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] sgpr_mem [0:127];
  logic [31:0] vgpr_mem [0:255];
  logic [31:0] inl_tab  [128:208];

  // Register files: data appears the cycle after the strobe; garbage otherwise
  always @(posedge clk) begin
    bus.sgpr_rdata <= bus.sgpr_re ? sgpr_mem[bus.sgpr_addr] : $urandom;
    bus.vgpr_rdata <= bus.vgpr_re ? vgpr_mem[bus.vgpr_addr] : $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [7:0] vdst,
                                     input logic [7:0] vsrc1, input logic [8:0] src0);
    return {1'b0, op, vdst, vsrc1, src0};
  endfunction

  // Reference: value of src0 after resolution
  function automatic logic [31:0] model_src0(input logic [8:0] s, input logic [31:0] lit);
    if (s < 9'd128)       return sgpr_mem[s[6:0]];
    else if (s <= 9'd208) return inl_tab[s];
    else if (s < 9'd255)  return 32'h0;
    else if (s == 9'd255) return lit;
    else                  return vgpr_mem[s[7:0]];
  endfunction

  function automatic int model_lat(input logic [8:0] s, input int lit_wait);
    if (s == 9'd255)                  return 3 + lit_wait + 1;
    else if (s < 9'd128 || s[8])      return 4;
    else                              return 3;
  endfunction

  task automatic run_txn(input string tag, input logic [31:0] instr, input logic [31:0] lit,
                         input int lit_wait, input int rdy_wait,
                         input logic [31:0] e_src0, input logic [31:0] e_src1,
                         input logic e_err, input int e_lat);
    int cyc;
    int lit_cnt;
    bit seen;
    bit both;
    int sg_n;
    int vg_n;
    logic [6:0] sg_a;
    logic [7:0] vg_a [4];
    logic [8:0] s0;
    logic [7:0] vs1;
    logic [31:0] snap0, snap1;
    logic [14:0] snapf;
    s0 = instr[8:0];
    vs1 = instr[16:9];
    cyc = 0; lit_cnt = 0; seen = 0; both = 0; sg_n = 0; vg_n = 0; sg_a = '0;
    for (int i = 0; i < 4; i++) vg_a[i] = '0;
    chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b0;
      if (bus.sgpr_re && bus.vgpr_re) both = 1;
      if (bus.sgpr_re) begin sg_n++; sg_a = bus.sgpr_addr; end
      if (bus.vgpr_re) begin
        if (vg_n < 4) vg_a[vg_n] = bus.vgpr_addr;
        vg_n++;
      end
      if (bus.lit_ready) begin
        lit_cnt++;
        bus.lit_valid = (lit_cnt > lit_wait);
        bus.lit_data  = bus.lit_valid ? lit : $urandom;
      end else begin
        bus.lit_valid = 1'b0;
      end
      if (bus.out_valid) seen = 1;
    end
    bus.lit_valid = 1'b0;
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_latency"}, cyc, e_lat);
    chk({tag, "_src0"}, bus.out_src0, e_src0);
    chk({tag, "_src1"}, bus.out_src1, e_src1);
    chk({tag, "_err"}, bus.out_err, e_err);
    chk({tag, "_op"}, bus.out_op, instr[30:25]);
    chk({tag, "_vdst"}, bus.out_vdst, instr[24:17]);
    chk({tag, "_in_ready_out"}, bus.in_ready, 0);
    chk({tag, "_dual_read"}, both, 0);
    chk({tag, "_lit_cycles"}, lit_cnt, (s0 == 9'd255) ? lit_wait + 1 : 0);
    chk({tag, "_sgpr_reads"}, sg_n, (s0 < 9'd128) ? 1 : 0);
    if (s0 < 9'd128) chk({tag, "_sgpr_addr"}, sg_a, s0[6:0]);
    chk({tag, "_vgpr_reads"}, vg_n, s0[8] ? 2 : 1);
    if (s0[8]) begin
      chk({tag, "_vgpr_addr0"}, vg_a[0], s0[7:0]);
      chk({tag, "_vgpr_addr1"}, vg_a[1], vs1);
    end else begin
      chk({tag, "_vgpr_addr0"}, vg_a[0], vs1);
    end
    snap0 = bus.out_src0;
    snap1 = bus.out_src1;
    snapf = {bus.out_op, bus.out_vdst, bus.out_err};
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
      chk({tag, "_hold_data"}, {bus.out_src0, bus.out_src1},
          {snap0, snap1});
      chk({tag, "_hold_fields"}, {bus.out_op, bus.out_vdst, bus.out_err}, snapf);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_post_hs_valid"}, bus.out_valid, 0);
    chk({tag, "_post_hs_in_ready"}, bus.in_ready, 1);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] lit;
    int          lit_wait;
    int          rdy_wait;
    logic [31:0] e_src0;
    logic [31:0] e_src1;
    logic        e_err;
    int          e_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  s0;
    logic [31:0] ins, lit;
    int lw, rw;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0;
    bus.lit_valid = 1'b0; bus.lit_data = '0;
    bus.out_ready = 1'b0;

    for (int i = 0; i < 128; i++) sgpr_mem[i] = $urandom;
    for (int i = 0; i < 256; i++) vgpr_mem[i] = $urandom;
    vgpr_mem[5]   = 32'h3F800000;
    vgpr_mem[7]   = 32'h40000000;
    vgpr_mem[2]   = 32'h00000010;
    vgpr_mem[0]   = 32'h11111111;
    sgpr_mem[12]  = 32'h00000055;
    sgpr_mem[127] = 32'h00007F7F;
    inl_tab[128] = 32'h0;
    for (int k = 1; k <= 64; k++) inl_tab[128 + k] = 32'(k);
    for (int k = 1; k <= 16; k++) inl_tab[192 + k] = 32'(-k);

    vecs[0] = '{"v5_v7",   mk(6'd3, 8'd9, 8'd7, 9'h105),  32'h0, 0, 0, 32'h3F800000, 32'h40000000, 1'b0, 4};
    vecs[1] = '{"inl_m1",  mk(6'd1, 8'd4, 8'd2, 9'd193),  32'h0, 0, 0, 32'hFFFFFFFF, 32'h00000010, 1'b0, 3};
    vecs[2] = '{"lit",     mk(6'd5, 8'd1, 8'd7, 9'd255),  32'hDEADBEEF, 5, 0, 32'hDEADBEEF, 32'h40000000, 1'b0, 9};
    vecs[3] = '{"s12",     mk(6'd2, 8'd3, 8'd2, 9'd12),   32'h0, 0, 1, 32'h00000055, 32'h00000010, 1'b0, 4};
    vecs[4] = '{"ill230",  mk(6'd7, 8'd8, 8'd5, 9'd230),  32'h0, 0, 10, 32'h00000000, 32'h3F800000, 1'b1, 3};
    vecs[5] = '{"inl_0",   mk(6'd9, 8'd2, 8'd7, 9'd128),  32'h0, 0, 0, 32'h00000000, 32'h40000000, 1'b0, 3};
    vecs[6] = '{"inl_m16", mk(6'd63, 8'd255, 8'd2, 9'd208), 32'h0, 0, 2, 32'hFFFFFFF0, 32'h00000010, 1'b0, 3};
    vecs[7] = '{"inl_64",  mk(6'd0, 8'd0, 8'd5, 9'd192),  32'h0, 0, 0, 32'h00000040, 32'h3F800000, 1'b0, 3};
    vecs[8] = '{"s127_v0", mk(6'd4, 8'd6, 8'd0, 9'd127),  32'h0, 0, 0, 32'h00007F7F, 32'h11111111, 1'b0, 4};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_lit_ready", bus.lit_ready, 0);
    chk("rst_re", {bus.sgpr_re, bus.vgpr_re}, 0);
    chk("rst_data", {bus.out_src0, bus.out_src1, bus.out_op, bus.out_vdst, bus.out_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].tag, vecs[i].instr, vecs[i].lit, vecs[i].lit_wait, vecs[i].rdy_wait,
              vecs[i].e_src0, vecs[i].e_src1, vecs[i].e_err, vecs[i].e_lat);

    // Randomized instructions against the model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: s0 = 9'($urandom_range(0, 127));
        1: s0 = 9'($urandom_range(128, 208));
        2: s0 = 9'($urandom_range(209, 254));
        3: s0 = 9'd255;
        default: s0 = 9'($urandom_range(256, 511));
      endcase
      ins = mk(6'($urandom), 8'($urandom), 8'($urandom), s0);
      ins[31] = 1'($urandom);
      lit = $urandom;
      lw = $urandom_range(0, 4);
      rw = $urandom_range(0, 3);
      run_txn("rnd", ins, lit, lw, rw, model_src0(s0, lit), vgpr_mem[ins[16:9]],
              (s0 >= 9'd209 && s0 <= 9'd254), model_lat(s0, lw));
    end

    // Reset while in RV1 (inline src0 already loaded)
    bus.in_valid = 1'b1;
    bus.in_instr = mk(6'd2, 8'd1, 8'd2, 9'd193);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rv1_vgpr_re", bus.vgpr_re, 1);
    chk("rv1_src0", bus.out_src0, 32'hFFFFFFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrv1_vgpr_re", bus.vgpr_re, 0);
    chk("rstrv1_out_valid", bus.out_valid, 0);
    chk("rstrv1_in_ready", bus.in_ready, 0);
    chk("rstrv1_lit_ready", bus.lit_ready, 0);
    chk("rstrv1_src0", bus.out_src0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstrv1_release_in_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("rstrv1_idle_in_ready", bus.in_ready, 1);
    chk("rstrv1_idle_valid", bus.out_valid, 0);

    // Reset while stalled in OUT
    bus.in_valid = 1'b1;
    bus.in_instr = mk(6'd11, 8'd12, 8'd7, 9'd150);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("out_stall_valid", bus.out_valid, 1);
    chk("out_stall_src0", bus.out_src0, 32'd22);
    #2 rst_n = 1'b0;
    #1;
    chk("rstout_valid", bus.out_valid, 0);
    chk("rstout_data", {bus.out_src0, bus.out_src1, bus.out_op, bus.out_vdst}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstout_release_in_ready", bus.in_ready, 1);
    @(negedge clk);

    run_txn("after_rst", vecs[0].instr, 32'h0, 0, 0, 32'h3F800000, 32'h40000000, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
